// File: rtl/mult_accum_pkg.sv
// Shared types, default widths and sizing helper for the mult_accum burst accumulator.
package mult_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned PROD_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 16;

    // Bits needed to hold a term count in 0..n without wrapping.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n + 1 <= 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/acc_prefix_adder.sv
// Kogge-Stone parallel-prefix adder (carry-in 0) returning sum and carry out.
module acc_prefix_adder #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned LVLS = $clog2(W);

    logic [W-1:0] g_lv [LVLS+1];
    logic [W-1:0] p_lv [LVLS+1];

    // Each level applies a row of black cells at span 2^l; bits below the span pass through.
    always_comb begin
        g_lv[0] = a & b;
        p_lv[0] = a ^ b;
        for (int l = 0; l < int'(LVLS); l++) begin
            g_lv[l+1] = g_lv[l] | (p_lv[l] & (g_lv[l] << (1 << l)));
            p_lv[l+1] = p_lv[l] & ((p_lv[l] << (1 << l)) | ~({W{1'b1}} << (1 << l)));
        end
    end

    assign sum  = p_lv[0] ^ {g_lv[LVLS][W-2:0], 1'b0};
    assign cout = g_lv[LVLS][W-1];

endmodule

// File: rtl/mult_accum.sv
// Burst accumulator: sums N_TERMS unsigned products via valid/ready and presents the total.
// Build option: MULT_ACCUM_SATURATE_EN clamps the sum at all-ones on carry out instead of wrapping.
module mult_accum
    import mult_accum_pkg::*;
#(
    parameter int unsigned PROD_W  = PROD_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned N_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned CNT_W = cnt_w(N_TERMS);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [ACC_W-1:0]  acc, acc_nxt, sum;
    logic              carry, xfer, last;

    acc_prefix_adder #(.W(ACC_W)) u_add (
        .a    (acc),
        .b    (ACC_W'(prod)),
        .sum  (sum),
        .cout (carry)
    );

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);
    assign acc_out  = acc;
    assign xfer     = in_ready && in_valid;
    assign last     = (count == CNT_W'(N_TERMS - 1));

`ifdef MULT_ACCUM_SATURATE_EN
    // Once a carry has been seen the sum is pinned at all-ones for the rest of the burst.
    assign acc_nxt = (carry || overflow) ? {ACC_W{1'b1}} : sum;
`else
    assign acc_nxt = sum;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (xfer && last) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == HOLD);
            if (state == IDLE && start) begin
                acc      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (xfer) begin
                acc      <= acc_nxt;
                count    <= count + CNT_W'(1);
                overflow <= overflow | carry;
            end
        end
    end

endmodule

// File: tb/tb_mult_accum.sv
// Directed + random bench for mult_accum; a 16-bit and a 9-bit instance share all stimulus.
module tb_mult_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  prod;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready, out_valid, busy, overflow;
    logic [15:0] acc_out;
    logic        in_ready9, out_valid9, busy9, overflow9;
    logic [8:0]  acc_out9;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int unsigned terms [4];

    always #5 clk = ~clk;

    mult_accum #(.PROD_W(8), .ACC_W(16), .N_TERMS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .prod(prod), .in_valid(in_valid),
        .in_ready(in_ready), .acc_out(acc_out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overflow(overflow)
    );

    mult_accum #(.PROD_W(8), .ACC_W(9), .N_TERMS(4)) u_dut9 (
        .clk(clk), .rst(rst), .start(start), .prod(prod), .in_valid(in_valid),
        .in_ready(in_ready9), .acc_out(acc_out9), .out_valid(out_valid9),
        .out_ready(out_ready), .busy(busy9), .overflow(overflow9)
    );

    always @(posedge clk)
        if (!rst && in_valid && in_ready) xfers++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: true sum of accepted terms reduced to a W-bit register.
    function automatic logic [31:0] exp_acc(input int unsigned s, input int unsigned w);
        int unsigned mx;
        mx = (1 << w) - 1;
`ifdef MULT_ACCUM_SATURATE_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    task automatic burst(input int gap, input bit junk, input int bp_cycles);
        int unsigned s;
        int base;
        logic [15:0] held;
        s = 0;
        out_ready = (bp_cycles == 0);
        @(negedge clk);
        start = 1'b1;
        if (junk) begin
            in_valid = 1'b1;
            prod     = 8'hFF;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("busy_accum", busy, 1);
        chk("acc_cleared", acc_out, 0);
        base = xfers;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                chk("in_ready_gap", in_ready, 1);
                @(negedge clk);
            end
            chk("in_ready_term", in_ready, 1);
            in_valid = 1'b1;
            prod     = 8'(terms[i]);
            @(negedge clk);
            in_valid = 1'b0;
            s += terms[i];
            chk("acc16", acc_out, exp_acc(s, 16));
            chk("acc9", acc_out9, exp_acc(s, 9));
            chk("out_valid_last", out_valid, (i == 3) ? 1 : 0);
        end
        chk("ovf16", overflow, (s > 32'hFFFF) ? 1 : 0);
        chk("ovf9", overflow9, (s > 32'h1FF) ? 1 : 0);
        chk("in_ready_hold", in_ready, 0);
        held = acc_out;
        for (int k = 0; k < bp_cycles; k++) begin
            start = k[0];
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_acc", acc_out, held);
            chk("bp_ready", in_ready, 0);
        end
        if (bp_cycles > 0) begin
            start     = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_acc_kept", acc_out, held);
        chk("xfer_count", xfers - base, 4);
        @(negedge clk);
        chk("start_not_queued", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; prod = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_acc", acc_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        terms = '{32'h01, 32'h09, 32'hE1, 32'h10};
        burst(0, 1'b0, 0);
        chk("basic_sum", acc_out, 16'h00FB);
        burst(2, 1'b0, 0);
        burst(0, 1'b0, 5);

        terms = '{32'hE1, 32'hE1, 32'hE1, 32'hE1};
        burst(0, 1'b0, 0);
`ifdef MULT_ACCUM_SATURATE_EN
        chk("ovf_burst9", acc_out9, 9'h1FF);
`else
        chk("ovf_burst9", acc_out9, 9'h184);
`endif
        chk("ovf_flag9", overflow9, 1);
        chk("ovf_burst16", acc_out, 16'h0384);

        terms = '{32'h05, 32'h06, 32'h07, 32'h08};
        burst(0, 1'b1, 0);
        chk("junk_excluded", acc_out, 16'h001A);

        // Abandon a burst with an asynchronous reset between edges.
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; prod = 8'h33;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_rst_acc", acc_out, 16'h0066);
        #2 rst = 1'b1;
        #1;
        chk("midrst_acc", acc_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        terms = '{32'h02, 32'h02, 32'h02, 32'h02};
        burst(0, 1'b0, 0);
        chk("fresh_sum", acc_out, 16'h0008);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) terms[i] = $urandom_range(0, 255);
            burst(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
